lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the single-cycle core's execute stage and the byte-strobed data memory.
- Decodes RISC-V load/store size and sign from funct3, and drives the memory's word-shifted byte addresses, write/read strobes and lane-aligned write data.
- Reassembles and sign/zero-extends load data.
- Splits accesses the memory cannot perform in one strobe pattern into sequential byte accesses, and signals completion with a one-cycle done pulse.

Parameters:
- DEPTH, 128, memory depth in 32-bit words.
- WIDTH, 32, data width; fixed at 32, with a 4-bit strobe.
- AW, $clog2(DEPTH)+2, byte-address width driven to the memory.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- req_valid  in  1  core request; accepted when req_ready=1
- req_ready  out  1  high only in IDLE
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3
- req_addr  in  32  byte address; only [AW-1:0] used
- req_wdata  in  32  store data, LSB-justified
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; illegal funct3
- rdata  out  32  load result; held until next done
- mem_we  out  1  memory write enable
- mem_wr_addr  out  AW  memory write byte address
- mem_rd_addr  out  AW  memory read byte address
- mem_wr_strb  out  4  write byte strobe
- mem_rd_strb  out  4  read byte strobe
- mem_wr_din  out  32  lane-aligned write data
- mem_rd_dout  in  32  combinational memory read data

Behaviour:
- Reset: the state machine enters IDLE. All outputs are 0 except req_ready=1. rdata=0.
- States:
  - IDLE: on req_valid, latch request; size/offset decode selects single or split mode; go to ACCESS.
  - ACCESS: one memory access per cycle; a 2-bit byte counter steps in split mode; after the last access go to RESP.
  - RESP: done=1 for exactly one cycle, then IDLE.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else skips ACCESS. It goes IDLE->RESP with err=1 and rdata=0, and issues no memory strobe.
- Single mode: used when the access maps to a legal memory pattern.
  - Legal patterns: byte at any offset; half at offset 0/1/2 (0011/0110/1100); word at offset 0 (1111).
  - Exactly one ACCESS cycle. Latency is accept to done = 2 cycles.
- Split mode: used for half at offset 3 and word at offsets 1/2/3.
  - Performs N=size one-byte accesses.
  - Access k uses address (addr+k) mod 2^AW and strobe one-hot at lane (addr+k)[1:0].
  - Latency is N+1 cycles. Wrap across the top of the address space to 0 is legal.
- Store lane placement: byte k of req_wdata drives lane (addr+k)[1:0] of mem_wr_din. All other lanes are 0.
- Store strobes: mem_we=1 and mem_wr_strb are nonzero only in ACCESS; mem_rd_strb=0 for stores.
- Load capture: mem_rd_strb is nonzero only in ACCESS during a load. Only strobed lanes of mem_rd_dout are captured; unstrobed lanes (0x00 or 0xFF fill) are ignored.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. rdata updates when done asserts.
- mem_wr_addr = mem_rd_addr = current access address.
- req_valid in non-IDLE states is ignored; the core must hold the request until req_ready.
- An asynchronous reset mid-ACCESS forces IDLE immediately and drops mem_we the same instant. Partially written split stores are not rolled back, and no done is emitted.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> single write strb 1111; load done 2 cycles after accept; rdata=0xDEADBEEF.
- With mem word 0x8070F0FF at 0x20: LB 0x21 -> rdata 0xFFFFFFF0; LBU 0x21 -> 0x000000F0; LH 0x22 -> 0xFFFF8070; LHU 0x22 -> 0x00008070.
- SH addr 0x23 data 0x1234 -> two ACCESS cycles: strb 1000 lane3=0x34 at 0x23, then strb 0001 lane0=0x12 at 0x24; done at cycle 3; subsequent LHU 0x23 -> 0x00001234.
- SW addr 0x31 data 0x44332211 -> four byte writes to 0x31..0x34; LW 0x30 then LW 0x34 show 0x332211xx and 0xxxxxxx44; done 5 cycles after accept.
- funct3=011 load and funct3=100 store -> no mem_we and no rd_strb; done with err=1, rdata=0, 1 cycle after accept.
- Reset asserted during the 2nd byte of a split SW -> mem_we falls immediately, req_ready=1 after release, no done pulse; only byte 0 written.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the core execute stage and the byte-strobed
// data memory. Accesses that fit one strobe pattern take a single memory
// cycle. Misaligned halves and words are broken into sequential byte
// accesses. Completion is signalled by a one-cycle done pulse.
//
// state  | meaning
// IDLE   | ready for a request, latch it on req_valid
// ACCESS | one memory access per cycle (several in split mode)
// RESP   | done pulse, rdata/err valid
module lsu_mem_ctrl #(
   parameter int DEPTH = 128,
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(DEPTH) + 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_store,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] rdata,
   output logic             mem_we,
   output logic [AW-1:0]    mem_wr_addr,
   output logic [AW-1:0]    mem_rd_addr,
   output logic [3:0]       mem_wr_strb,
   output logic [3:0]       mem_rd_strb,
   output logic [WIDTH-1:0] mem_wr_din,
   input  logic [WIDTH-1:0] mem_rd_dout
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            r_state, w_next;
   logic              r_store;
   logic [2:0]        r_f3;
   logic [AW-1:0]     r_addr;
   logic [WIDTH-1:0]  r_wdata;
   logic              r_split;
   logic [1:0]        r_nlast;
   logic [1:0]        r_cnt;
   logic [WIDTH-1:0]  r_buf;
   logic              r_err;
   logic [WIDTH-1:0]  r_rdata;

   logic              w_legal;
   logic [1:0]        w_req_nlast;
   logic              w_req_split;
   logic [AW-1:0]     w_acc_addr;
   logic [1:0]        w_lane;
   logic              w_last;
   logic [3:0]        w_strb;
   logic [WIDTH-1:0]  w_bmask;
   logic [WIDTH-1:0]  w_din;
   logic [7:0]        w_wbyte;
   logic [63:0]       w_cat;
   logic [WIDTH-1:0]  w_buf_next;
   logic [WIDTH-1:0]  w_ext;
   logic              w_unused_addr;

   assign w_unused_addr = ^req_addr[31:AW];

   // Request decode: legality, size and whether the access must be split
   always_comb begin
      w_legal     = 1'b0;
      w_req_nlast = 2'd0;
      w_req_split = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: w_legal = 1'b1;
         3'b100, 3'b101:         w_legal = !req_store;
         default:                w_legal = 1'b0;
      endcase
      case (req_funct3[1:0])
         2'b01: begin
            w_req_nlast = 2'd1;
            w_req_split = (req_addr[1:0] == 2'd3);
         end
         2'b10: begin
            w_req_nlast = 2'd3;
            w_req_split = (req_addr[1:0] != 2'd0);
         end
         default: begin
            w_req_nlast = 2'd0;
            w_req_split = 1'b0;
         end
      endcase
   end

   // Current access address, strobe pattern and lane-aligned write data
   always_comb begin
      w_acc_addr = r_addr + AW'(r_cnt);
      w_lane     = w_acc_addr[1:0];
      w_last     = !r_split || (r_cnt == r_nlast);
      w_wbyte    = r_wdata[{r_cnt, 3'b000} +: 8];
      if (r_split) begin
         w_strb = 4'b0001 << w_lane;
      end else begin
         case (r_nlast)
            2'd0:    w_strb = 4'b0001 << r_addr[1:0];
            2'd1:    w_strb = 4'b0011 << r_addr[1:0];
            default: w_strb = 4'b1111;
         endcase
      end
      w_bmask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
      if (r_split)
         w_din = {24'd0, w_wbyte} << {w_lane, 3'b000};
      else
         w_din = (r_wdata << {r_addr[1:0], 3'b000}) & w_bmask;
   end

   // Load reassembly: rotate the strobed lanes down to byte 0, then extend
   always_comb begin
      w_cat      = {mem_rd_dout, mem_rd_dout};
      w_buf_next = r_buf;
      if (r_split)
         w_buf_next[{r_cnt, 3'b000} +: 8] = mem_rd_dout[{w_lane, 3'b000} +: 8];
      else
         w_buf_next = w_cat[{r_addr[1:0], 3'b000} +: 32];
      case (r_f3[1:0])
         2'b00:   w_ext = r_f3[2] ? {24'd0, w_buf_next[7:0]}
                                  : {{24{w_buf_next[7]}}, w_buf_next[7:0]};
         2'b01:   w_ext = r_f3[2] ? {16'd0, w_buf_next[15:0]}
                                  : {{16{w_buf_next[15]}}, w_buf_next[15:0]};
         default: w_ext = w_buf_next;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next state and memory-side outputs; nothing is driven outside ACCESS
   always_comb begin
      w_next      = r_state;
      req_ready   = 1'b0;
      done        = 1'b0;
      mem_we      = 1'b0;
      mem_wr_addr = '0;
      mem_rd_addr = '0;
      mem_wr_strb = 4'b0000;
      mem_rd_strb = 4'b0000;
      mem_wr_din  = '0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = w_legal ? ACCESS : RESP;
         end
         ACCESS: begin
            mem_we      = r_store;
            mem_wr_addr = w_acc_addr;
            mem_rd_addr = w_acc_addr;
            mem_wr_strb = r_store ? w_strb : 4'b0000;
            mem_rd_strb = r_store ? 4'b0000 : w_strb;
            mem_wr_din  = r_store ? w_din : '0;
            if (w_last) w_next = RESP;
         end
         RESP: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign err   = done & r_err;
   assign rdata = r_rdata;

   // Request latch, byte counter and load result capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_store <= 1'b0;
         r_f3    <= 3'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_split <= 1'b0;
         r_nlast <= 2'd0;
         r_cnt   <= 2'd0;
         r_buf   <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_store <= req_store;
                  r_f3    <= req_funct3;
                  r_addr  <= req_addr[AW-1:0];
                  r_wdata <= req_wdata;
                  r_split <= w_req_split;
                  r_nlast <= w_req_nlast;
                  r_cnt   <= 2'd0;
                  r_buf   <= '0;
                  r_err   <= !w_legal;
                  if (!w_legal) r_rdata <= '0;
               end
            end
            ACCESS: begin
               r_cnt <= r_cnt + 2'd1;
               if (!r_store) begin
                  r_buf <= w_buf_next;
                  if (w_last) r_rdata <= w_ext;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-strobed memory model whose
// unstrobed read lanes return 0xFF.
module tb_lsu_mem_ctrl;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_store = 1'b0;
   logic [2:0]    req_funct3 = 3'd0;
   logic [31:0]   req_addr = 32'd0;
   logic [31:0]   req_wdata = 32'd0;
   logic          done, err;
   logic [31:0]   rdata;
   logic          mem_we;
   logic [AW-1:0] mem_wr_addr, mem_rd_addr;
   logic [3:0]    mem_wr_strb, mem_rd_strb;
   logic [31:0]   mem_wr_din, mem_rd_dout;

   lsu_mem_ctrl dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .done(done), .err(err), .rdata(rdata),
      .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
      .mem_wr_strb(mem_wr_strb), .mem_rd_strb(mem_rd_strb),
      .mem_wr_din(mem_wr_din), .mem_rd_dout(mem_rd_dout)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:127] = '{default: 32'd0};
   logic        pl_en = 1'b0;
   logic [6:0]  pl_idx = 7'd0;
   logic [31:0] pl_val = 32'd0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      else if (mem_we)
         for (int l = 0; l < 4; l++)
            if (mem_wr_strb[l]) mem[mem_wr_addr[AW-1:2]][8*l +: 8] <= mem_wr_din[8*l +: 8];
   end

   always_comb begin
      mem_rd_dout = 32'hFFFF_FFFF;
      for (int l = 0; l < 4; l++)
         if (mem_rd_strb[l]) mem_rd_dout[8*l +: 8] = mem[mem_rd_addr[AW-1:2]][8*l +: 8];
   end

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   logic [3:0]    log_strb [0:7];
   logic [AW-1:0] log_addr [0:7];
   logic [31:0]   log_din  [0:7];
   int            log_nwr, log_nrd;

   task automatic preload(input logic [6:0] idx, input logic [31:0] val);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_val = val;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat,
                       output logic [31:0] rd, output logic e);
      lat = 0; rd = 32'hX; e = 1'bX;
      log_nwr = 0; log_nrd = 0;
      @(negedge clk);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (mem_we && log_nwr < 8) begin
            log_strb[log_nwr] = mem_wr_strb;
            log_addr[log_nwr] = mem_wr_addr;
            log_din[log_nwr]  = mem_wr_din;
            log_nwr++;
         end
         if (mem_rd_strb != 4'd0) log_nrd++;
         if (done) begin
            lat = c; rd = rdata; e = err;
            break;
         end
      end
      if (lat == 0) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   int          lat;
   logic [31:0] rd;
   logic        e;
   int          ndone;

   initial begin
      #1;
      check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
      check_eq("rst_done",  {31'd0, done}, 32'd0);
      check_eq("rst_err",   {31'd0, err}, 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_we",    {31'd0, mem_we}, 32'd0);
      check_eq("rst_strb",  {24'd0, mem_wr_strb, mem_rd_strb}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // aligned word store then load
      xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, e);
      check_eq("sw_lat", lat, 2);
      check_eq("sw_nwr", log_nwr, 1);
      check_eq("sw_strb", {28'd0, log_strb[0]}, 32'hF);
      check_eq("sw_din", log_din[0], 32'hDEADBEEF);
      check_eq("sw_err", {31'd0, e}, 32'd0);
      xact(1'b0, 3'b010, 32'h10, 32'd0, lat, rd, e);
      check_eq("lw_lat", lat, 2);
      check_eq("lw_rdata", rd, 32'hDEADBEEF);
      check_eq("lw_nwr", log_nwr, 0);

      // byte/half sign and zero extension
      preload(7'h08, 32'h8070F0FF);
      xact(1'b0, 3'b000, 32'h21, 32'd0, lat, rd, e);
      check_eq("lb", rd, 32'hFFFFFFF0);
      xact(1'b0, 3'b100, 32'h21, 32'd0, lat, rd, e);
      check_eq("lbu", rd, 32'h000000F0);
      xact(1'b0, 3'b001, 32'h22, 32'd0, lat, rd, e);
      check_eq("lh", rd, 32'hFFFF8070);
      check_eq("lh_lat", lat, 2);
      xact(1'b0, 3'b101, 32'h22, 32'd0, lat, rd, e);
      check_eq("lhu", rd, 32'h00008070);

      // half store at offset 3 splits into two byte writes
      xact(1'b1, 3'b001, 32'h23, 32'h1234, lat, rd, e);
      check_eq("sh3_lat", lat, 3);
      check_eq("sh3_nwr", log_nwr, 2);
      check_eq("sh3_strb0", {28'd0, log_strb[0]}, 32'h8);
      check_eq("sh3_addr0", {23'd0, log_addr[0]}, 32'h23);
      check_eq("sh3_din0", log_din[0], 32'h34000000);
      check_eq("sh3_strb1", {28'd0, log_strb[1]}, 32'h1);
      check_eq("sh3_addr1", {23'd0, log_addr[1]}, 32'h24);
      check_eq("sh3_din1", log_din[1], 32'h00000012);
      xact(1'b0, 3'b101, 32'h23, 32'd0, lat, rd, e);
      check_eq("lhu3", rd, 32'h00001234);
      check_eq("lhu3_lat", lat, 3);
      check_eq("lhu3_nrd", log_nrd, 2);

      // misaligned word store becomes four byte writes
      xact(1'b1, 3'b010, 32'h31, 32'h44332211, lat, rd, e);
      check_eq("sw1_lat", lat, 5);
      check_eq("sw1_nwr", log_nwr, 4);
      check_eq("sw1_addr3", {23'd0, log_addr[3]}, 32'h34);
      check_eq("sw1_din3", log_din[3], 32'h00000044);
      xact(1'b0, 3'b010, 32'h30, 32'd0, lat, rd, e);
      check_eq("lw30", rd, 32'h33221100);
      xact(1'b0, 3'b010, 32'h34, 32'd0, lat, rd, e);
      check_eq("lw34", rd, 32'h00000044);

      // split word load wrapping past the top of the address space
      preload(7'h7F, 32'hAABB0000);
      preload(7'h00, 32'h0000DDCC);
      xact(1'b0, 3'b010, 32'hFFFF_F1FE, 32'd0, lat, rd, e);
      check_eq("lw_wrap", rd, 32'hDDCCAABB);
      check_eq("lw_wrap_lat", lat, 5);
      check_eq("lw_wrap_nrd", log_nrd, 4);

      // illegal funct3
      xact(1'b0, 3'b011, 32'h10, 32'd0, lat, rd, e);
      check_eq("ill_ld_lat", lat, 1);
      check_eq("ill_ld_err", {31'd0, e}, 32'd1);
      check_eq("ill_ld_rdata", rd, 32'd0);
      check_eq("ill_ld_acc", log_nwr + log_nrd, 0);
      xact(1'b1, 3'b100, 32'h10, 32'h55555555, lat, rd, e);
      check_eq("ill_st_lat", lat, 1);
      check_eq("ill_st_err", {31'd0, e}, 32'd1);
      check_eq("ill_st_acc", log_nwr + log_nrd, 0);
      xact(1'b0, 3'b010, 32'h10, 32'd0, lat, rd, e);
      check_eq("ill_st_nowrite", rd, 32'hDEADBEEF);

      // reset during the second byte of a split word store
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h41; req_wdata = 32'h44332211;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check_eq("rst_b0_strb", {27'd0, mem_we, mem_wr_strb}, 32'h12);
      @(negedge clk);
      check_eq("rst_b1_strb", {27'd0, mem_we, mem_wr_strb}, 32'h14);
      reset = 1'b0;
      #1;
      check_eq("rst_mid_we", {31'd0, mem_we}, 32'd0);
      check_eq("rst_mid_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      ndone = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check_eq("rst_no_done", ndone, 0);
      check_eq("rst_ready_after", {31'd0, req_ready}, 32'd1);
      check_eq("rst_partial", mem[7'h10], 32'h00001100);
      check_eq("rst_untouched", mem[7'h11], 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout obs=running exp=finished");
      $fatal(1);
   end

endmodule
